platform_scroll_ctrl: RTL and testbench

//  Owns the platform slot table (y, x, active) that the platform renderer draws from.

---
 rtl/doodle_pkg.sv | 20 ++
 rtl/platform_lfsr.sv | 25 ++
 rtl/platform_scroll_ctrl.sv | 154 +++++++++++++++
 tb/tb_platform_scroll_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Shared types and constants for the doodle platform subsystem: coordinates,
// platform slot record, scroll FSM states and LFSR constants.
package doodle_pkg;

   localparam int COORD_W  = 11;
   localparam int SCREEN_H = 600;

   typedef logic signed [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t y;
      coord_t x;
   } platform_t;

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} scroll_state_t;

   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/platform_lfsr.sv
// 16-bit Galois LFSR that drives platform recycling randomness.
// Loads the seed on request (a zero seed becomes the default) and advances on step.
module platform_lfsr
   import doodle_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] state
);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LFSR_DEFAULT_SEED;
      end else if (load) begin
         state <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
      end else if (step) begin
         state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
      end
   end

endmodule

// File: rtl/platform_scroll_ctrl.sv
// Platform slot table owner: sweeps one slot per cycle each frame, scrolling and recycling.
// Optional PLATFORM_RANDOM_EN adds randomized x/activation with a maximum empty-row gap.
module platform_scroll_ctrl
   import doodle_pkg::*;
#(
   parameter int N_ROWS    = 31,
   parameter int N_COLS    = 3,
   parameter int ROW_PITCH = 30,
   parameter int Y_TOP     = -162,
   parameter int X_LEFT    = 342,
   parameter int X_PITCH   = 114,
   parameter int MAX_GAP   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       frame_start,
   input  logic [5:0]                 scroll_amount,
   input  logic [15:0]                seed,
   output platform_t                  platforms [N_ROWS*N_COLS],
   output logic [N_ROWS*N_COLS-1:0]   platform_activation,
   output logic                       busy,
   output logic                       scroll_done,
   output logic                       overrun
);

   localparam int N     = N_ROWS * N_COLS;
   localparam int IDX_W = $clog2(N);
   localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam logic signed [11:0] Y_LIMIT = 12'(SCREEN_H);
   localparam logic signed [11:0] Y_WRAP  = 12'(N_ROWS * ROW_PITCH);

   scroll_state_t      state, state_nxt;
   logic [5:0]         amt;
   logic [IDX_W-1:0]   idx;
   logic [COL_W-1:0]   col;
   logic               last_slot, last_col;
   logic signed [11:0] y_sum, y_new;
   logic               recycle;
   coord_t             x_nom, x_new;
   logic               act_new;

   assign last_slot = (idx == IDX_W'(N - 1));
   assign last_col  = (col == COL_W'(N_COLS - 1));

`ifdef PLATFORM_RANDOM_EN
   localparam int GAP_W = $clog2(MAX_GAP) + 1;

   logic [15:0]      lfsr;
   logic             seeded;
   logic [GAP_W-1:0] gap_cnt;
   logic             row_any, row_act, force_act;
   logic             unused_lfsr;

   assign unused_lfsr = ^lfsr[15:8];

   platform_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (!seeded),
      .seed  (seed),
      .step  ((state == SWEEP) && recycle),
      .state (lfsr)
   );
`else
   localparam int unused_max_gap = MAX_GAP;
   logic unused_seed;
   assign unused_seed = ^seed;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      busy        = 1'b0;
      scroll_done = 1'b0;
      unique case (state)
         IDLE:  if (frame_start) state_nxt = (scroll_amount != 6'd0) ? SWEEP : DONE;
         SWEEP: begin
            busy = 1'b1;
            if (last_slot) state_nxt = DONE;
         end
         DONE: begin
            scroll_done = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Slot datapath: 12-bit intermediate so y + amt can never wrap before the compare.
   always_comb begin
      y_sum   = {platforms[idx].y[COORD_W-1], platforms[idx].y} + {6'd0, amt};
      recycle = (y_sum >= Y_LIMIT);
      y_new   = recycle ? (y_sum - Y_WRAP) : y_sum;
      x_nom   = coord_t'(X_LEFT + int'(col) * X_PITCH);
`ifdef PLATFORM_RANDOM_EN
      force_act = last_col && (gap_cnt == GAP_W'(MAX_GAP - 1));
      x_new     = x_nom + coord_t'({6'd0, lfsr[4:0]}) - coord_t'(16);
      act_new   = (lfsr[7:6] != 2'b00) || force_act;
      row_act   = act_new || ((col != '0) && row_any);
`else
      x_new   = x_nom;
      act_new = 1'b1;
`endif
   end

   // NOTE: the slot table is a flop array with per-slot reset values, not a RAM, so it is reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         amt     <= '0;
         idx     <= '0;
         col     <= '0;
         overrun <= 1'b0;
         for (int k = 0; k < N; k++) begin
            platforms[k].y <= coord_t'(Y_TOP + (k / N_COLS) * ROW_PITCH);
            platforms[k].x <= coord_t'(X_LEFT + (k % N_COLS) * X_PITCH);
         end
         platform_activation <= '1;
      end else begin
         state <= state_nxt;
         if (frame_start) begin
            if (state == IDLE) amt <= scroll_amount;
            else               overrun <= 1'b1;
         end
         if (state == SWEEP) begin
            platforms[idx].y <= coord_t'(y_new);
            if (recycle) begin
               platforms[idx].x         <= x_new;
               platform_activation[idx] <= act_new;
            end
            idx <= last_slot ? '0 : idx + 1'b1;
            col <= last_col  ? '0 : col + 1'b1;
         end
      end
   end

`ifdef PLATFORM_RANDOM_EN
   // Rows recycle as a unit, so the gap counter updates on the last column of a recycled row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seeded  <= 1'b0;
         gap_cnt <= '0;
         row_any <= 1'b0;
      end else begin
         seeded <= 1'b1;
         if ((state == SWEEP) && recycle) begin
            row_any <= row_act;
            if (last_col) gap_cnt <= row_act ? '0 : gap_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_platform_scroll_ctrl.sv
// Self-checking bench for platform_scroll_ctrl: per-slot scoreboard during sweeps,
// a table of frame vectors, and hand-written overrun / mid-sweep reset sequences.
module tb_platform_scroll_ctrl;
   import doodle_pkg::*;

   localparam int N_ROWS    = 31;
   localparam int N_COLS    = 3;
   localparam int ROW_PITCH = 30;
   localparam int Y_TOP     = -162;
   localparam int X_LEFT    = 342;
   localparam int X_PITCH   = 114;
   localparam int MAX_GAP   = 4;
   localparam int N         = N_ROWS * N_COLS;
   localparam int WRAP      = N_ROWS * ROW_PITCH;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             frame_start = 1'b0;
   logic [5:0]       scroll_amount = '0;
   logic [15:0]      seed = 16'h0001;
   platform_t        platforms [N];
   logic [N-1:0]     platform_activation;
   logic             busy, scroll_done, overrun;

   platform_scroll_ctrl #(
      .N_ROWS(N_ROWS), .N_COLS(N_COLS), .ROW_PITCH(ROW_PITCH), .Y_TOP(Y_TOP),
      .X_LEFT(X_LEFT), .X_PITCH(X_PITCH), .MAX_GAP(MAX_GAP)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .frame_start         (frame_start),
      .scroll_amount       (scroll_amount),
      .seed                (seed),
      .platforms           (platforms),
      .platform_activation (platform_activation),
      .busy                (busy),
      .scroll_done         (scroll_done),
      .overrun             (overrun)
   );

   always #5 clk = ~clk;

   typedef struct { int slot; int y; bit recycled; } slot_exp_t;
   typedef struct { int amt; int lat; } vec_t;

   int        checks   = 0;
   int        failures = 0;
   int        model_y [N];
   slot_exp_t sb [$];
   int        gap_run  = 0;

   task automatic check(input string name, input logic signed [31:0] actual,
                        input logic signed [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nom_x(input int k);
      return X_LEFT + (k % N_COLS) * X_PITCH;
   endfunction

   function automatic void reset_model();
      for (int k = 0; k < N; k++) model_y[k] = Y_TOP + (k / N_COLS) * ROW_PITCH;
   endfunction

   task automatic compare_table(input string tag);
      int bad;
      bad = 0;
      for (int k = 0; k < N; k++) begin
         if (int'(platforms[k].y) != model_y[k]) bad++;
`ifdef PLATFORM_RANDOM_EN
         if (int'(platforms[k].x) < nom_x(k) - 16 || int'(platforms[k].x) > nom_x(k) + 15) bad++;
`else
         if (int'(platforms[k].x) != nom_x(k) || platform_activation[k] !== 1'b1) bad++;
`endif
      end
      check({tag, "_table"}, bad, 0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_s0_y"}, platforms[0].y, -162);
      check({tag, "_s0_x"}, platforms[0].x, 342);
      check({tag, "_s92_y"}, platforms[92].y, 738);
      check({tag, "_s92_x"}, platforms[92].x, 570);
      check({tag, "_inactive_slots"}, $countones(~platform_activation), 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, scroll_done, 0);
      check({tag, "_overrun"}, overrun, 0);
      compare_table(tag);
   endtask

   task automatic reset_mid(input string tag);
      int saw;
      saw   = 0;
      rst_n = 1'b0;
      #1;
      sb.delete();
      reset_model();
      check_reset_state({tag, "_async"});
      repeat (3) begin
         tick();
         if (scroll_done !== 1'b0) saw++;
      end
      rst_n = 1'b1;
      repeat (N + 5) begin
         tick();
         if (scroll_done !== 1'b0) saw++;
      end
      check({tag, "_no_done"}, saw, 0);
      check_reset_state({tag, "_after"});
   endtask

   // Pushes the expected per-slot results, pulses frame_start, then pops one slot per
   // cycle as it becomes visible. ovr_at / rst_at inject a second pulse or a reset at cycle c.
   task automatic run_frame(input string tag, input int amt, input int exp_lat,
                            input int ovr_at, input int rst_at);
      int        c, bad_busy, bad_slot, y, any;
      bit        done_seen;
      slot_exp_t e;
      c = 1; done_seen = 1'b0; bad_busy = 0; bad_slot = 0;
      if (amt != 0) begin
         for (int k = 0; k < N; k++) begin
            y          = model_y[k] + amt;
            e.recycled = (y >= SCREEN_H);
            if (e.recycled) y -= WRAP;
            e.slot     = k;
            e.y        = y;
            sb.push_back(e);
            model_y[k] = y;
         end
      end
      frame_start   = 1'b1;
      scroll_amount = 6'(amt);
      tick();
      frame_start   = 1'b0;
      scroll_amount = 6'($urandom_range(0, 63));
      while (!done_seen && c <= 3 * N) begin
         if (busy !== ((amt != 0) && (c <= N))) bad_busy++;
         if (c >= 2 && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_slot_y"}, platforms[e.slot].y, e.y);
`ifdef PLATFORM_RANDOM_EN
            if (e.recycled) begin
               if (int'(platforms[e.slot].x) < nom_x(e.slot) - 16 ||
                   int'(platforms[e.slot].x) > nom_x(e.slot) + 15) bad_slot++;
               if (e.slot % N_COLS == N_COLS - 1) begin
                  any = 0;
                  for (int j = 0; j < N_COLS; j++) any += int'(platform_activation[e.slot - j]);
                  gap_run = (any == 0) ? gap_run + 1 : 0;
                  if (gap_run >= MAX_GAP) bad_slot++;
               end
            end
`else
            if (int'(platforms[e.slot].x) != nom_x(e.slot) ||
                platform_activation[e.slot] !== 1'b1) bad_slot++;
`endif
         end
         if (scroll_done === 1'b1) begin
            done_seen = 1'b1;
            check({tag, "_done_latency"}, c, exp_lat);
         end else if (c == rst_at) begin
            reset_mid(tag);
            return;
         end else begin
            if (c == ovr_at) begin
               frame_start   = 1'b1;
               scroll_amount = 6'd20;
            end
            tick();
            frame_start = 1'b0;
            c++;
         end
      end
      if (!done_seen) check({tag, "_done_timeout"}, 0, 1);
      check({tag, "_busy_profile"}, bad_busy, 0);
      check({tag, "_slot_xa"}, bad_slot, 0);
      check({tag, "_sb_left"}, sb.size(), 0);
      sb.delete();
      tick();
      check({tag, "_done_width"}, scroll_done, 0);
      check({tag, "_busy_after"}, busy, 0);
      compare_table(tag);
   endtask

   initial begin
      vec_t vecs [7];
      vecs = '{'{amt: 63, lat: 94}, '{amt: 0, lat: 1}, '{amt: 7, lat: 94},
               '{amt: 45, lat: 94}, '{amt: 1, lat: 94}, '{amt: 0, lat: 1},
               '{amt: 30, lat: 94}};

      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      reset_model();
      check_reset_state("reset");

      run_frame("amt10", 10, 94, -1, -1);
      check("amt10_s0_y", platforms[0].y, -152);
      check("amt10_s92_y", platforms[92].y, -182);

      run_frame("amt0", 0, 1, -1, -1);

      // Row 25 sits at 598: one more px leaves it on screen at 599, the next recycles it.
      run_frame("edge599", 1, 94, -1, -1);
      check("edge599_s75_y", platforms[75].y, 599);
      run_frame("edge600", 1, 94, -1, -1);
      check("edge600_s75_y", platforms[75].y, -330);

      foreach (vecs[i]) run_frame($sformatf("vec%0d", i), vecs[i].amt, vecs[i].lat, -1, -1);

      check("overrun_clear", overrun, 0);
      run_frame("overrun", 25, 94, 20, -1);
      check("overrun_set", overrun, 1);
      run_frame("overrun_hold", 5, 94, -1, -1);
      check("overrun_sticky", overrun, 1);

      run_frame("rst_mid", 17, 94, -1, 41);
      run_frame("post_rst", 12, 94, -1, -1);

`ifdef PLATFORM_RANDOM_EN
      for (int f = 0; f < 300; f++) run_frame("random", int'($urandom_range(20, 63)), 94, -1, -1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
